// File: rtl/adder_2bit_checker.sv
// Self-test engine for a small ripple adder: sweeps every {a,b,ci} vector,
// waits a settle interval, and compares {co,s} against a golden sum.
module adder_2bit_checker #(
  parameter int W             = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  output logic             ci_out,
  input  logic [W-1:0]     s_in,
  input  logic             co_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*W+1:0]   err_count,
  output logic             fail_valid,
  output logic [2*W:0]     fail_vec
);

  localparam int VW = 2 * W + 1;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [VW-1:0]   v;
  logic [CW-1:0]   settle_cnt;
  logic            last_vec;
  logic [W:0]      expected;
  logic [W:0]      observed;
  logic            mismatch;
  logic [2*W+1:0]  err_next;

  // Golden sum is taken from the registered operands, which hold v since DRIVE.
  always_comb begin
    expected = {1'b0, a_out} + {1'b0, b_out} + {{W{1'b0}}, ci_out};
    observed = {co_in, s_in};
    mismatch = (expected != observed);
    err_next = err_count + {{(2*W+1){1'b0}}, mismatch};
    last_vec = (v == {VW{1'b1}});
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: next-state gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = DRIVE;
      DRIVE:      state_next = SETTLE;
      SETTLE:     if (settle_cnt == '0) state_next = CHECK;
      CHECK:      state_next = last_vec ? DONE : DRIVE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v          <= '0;
      settle_cnt <= '0;
      a_out      <= '0;
      b_out      <= '0;
      ci_out     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            v          <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        DRIVE: begin
          a_out      <= v[VW-1:W+1];
          b_out      <= v[W:1];
          ci_out     <= v[0];
          settle_cnt <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        end
        CHECK: begin
          err_count <= err_next;
          if (mismatch && !fail_valid) begin
            fail_vec   <= v;
            fail_valid <= 1'b1;
          end
          // A miss on the final vector is already folded into err_next here.
          if (last_vec) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_next == '0);
          end else begin
            v <= v + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_2bit_checker.sv
// Scoreboard bench: sweep stimulus pushes expected results, per-DUT monitors
// pop and compare when done rises.
module tb_adder_2bit_checker;

  localparam int N = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start5 = 1'b0;
  int         mode = 0;

  logic [1:0] a_out, b_out, s_in;
  logic       ci_out, co_in, busy, done, pass, fail_valid;
  logic [5:0] err_count;
  logic [4:0] fail_vec;

  logic [1:0] a5, b5, s5;
  logic       ci5, co5, busy5, done5, pass5, fail_valid5;
  logic [5:0] err_count5;
  logic [4:0] fail_vec5;

  always #5 clk = ~clk;

  adder_2bit_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_out(a_out), .b_out(b_out), .ci_out(ci_out),
    .s_in(s_in), .co_in(co_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  adder_2bit_checker #(.W(2), .SETTLE_CYCLES(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5),
    .a_out(a5), .b_out(b5), .ci_out(ci5),
    .s_in(s5), .co_in(co5),
    .busy(busy5), .done(done5), .pass(pass5), .err_count(err_count5),
    .fail_valid(fail_valid5), .fail_vec(fail_vec5)
  );

  // Adder-under-test models: ideal, co stuck 0, s[0] stuck 0, 4-cycle delay.
  logic [2:0] sum0, sum5;
  logic [2:0] p0 [4];
  logic [2:0] p5 [4];

  always_comb sum0 = {1'b0, a_out} + {1'b0, b_out} + {2'b00, ci_out};
  always_comb sum5 = {1'b0, a5} + {1'b0, b5} + {2'b00, ci5};

  always @(posedge clk) begin
    p0[0] <= sum0; p0[1] <= p0[0]; p0[2] <= p0[1]; p0[3] <= p0[2];
    p5[0] <= sum5; p5[1] <= p5[0]; p5[2] <= p5[1]; p5[3] <= p5[2];
  end

  always_comb begin
    case (mode)
      0:       {co_in, s_in} = sum0;
      1:       {co_in, s_in} = {1'b0, sum0[1:0]};
      2:       {co_in, s_in} = {sum0[2:1], 1'b0};
      default: {co_in, s_in} = p0[3];
    endcase
  end
  always_comb {co5, s5} = p5[3];

  typedef struct {
    int         err;     // -1 means "any nonzero count"
    logic       fvalid;
    logic [4:0] fvec;
    logic       pass;
  } exp_t;

  exp_t q0[$];
  exp_t q5[$];
  int   n_vec = 0;
  int   n_miscmp = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int err, input logic fv, input logic [4:0] vec,
                              input logic ps);
    exp_t e;
    e.err = err; e.fvalid = fv; e.fvec = vec; e.pass = ps;
    return e;
  endfunction

  task automatic mon_done(input string tag, input exp_t e, input int cycles,
                          input int exp_cycles, input bit order_bad,
                          input logic [5:0] err, input logic fv,
                          input logic [4:0] fvec, input logic ps,
                          input logic [4:0] ops, input logic bz);
    if (e.err < 0) check({tag, " err_nonzero"}, int'(err != 0), 1);
    else           check({tag, " err_count"}, int'(err), e.err);
    check({tag, " fail_valid"}, int'(fv), int'(e.fvalid));
    if (e.err >= 0 && e.fvalid) check({tag, " fail_vec"}, int'(fvec), int'(e.fvec));
    check({tag, " pass"}, int'(ps), int'(e.pass));
    check({tag, " done_latency"}, cycles, exp_cycles);
    check({tag, " vector_order_errors"}, int'(order_bad), 0);
    check({tag, " last_vector_held"}, int'(ops), N - 1);
    check({tag, " busy_at_done"}, int'(bz), 0);
  endtask

  // Monitors: count busy cycles, verify operand stepping, score on done rise.
  int   bc0 = 0, bc5 = 0;
  bit   bad0 = 0, bad5 = 0;
  logic dq0 = 0, dq5 = 0;

  initial forever begin
    @(negedge clk);
    if (busy) begin
      bc0++;
      if (bc0 == 1) bad0 = 0;
      else if ({a_out, b_out, ci_out} != 5'((bc0 - 2) / 4)) bad0 = 1;
    end else begin
      if (done && !dq0) begin
        if (q0.size() == 0) check("dut spurious_done", q0.size(), 1);
        else mon_done("dut", q0.pop_front(), bc0, N * 4, bad0, err_count,
                      fail_valid, fail_vec, pass, {a_out, b_out, ci_out}, busy);
      end
      bc0 = 0;
    end
    dq0 = done;
  end

  initial forever begin
    @(negedge clk);
    if (busy5) begin
      bc5++;
      if (bc5 == 1) bad5 = 0;
      else if ({a5, b5, ci5} != 5'((bc5 - 2) / 7)) bad5 = 1;
    end else begin
      if (done5 && !dq5) begin
        if (q5.size() == 0) check("dut5 spurious_done", q5.size(), 1);
        else mon_done("dut5", q5.pop_front(), bc5, N * 7, bad5, err_count5,
                      fail_valid5, fail_vec5, pass5, {a5, b5, ci5}, busy5);
      end
      bc5 = 0;
    end
    dq5 = done5;
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("results_cleared", int'({done, pass, err_count, fail_valid, fail_vec}), 0);
  endtask

  task automatic drain0(input int limit);
    for (int i = 0; i < limit && q0.size() != 0; i++) @(negedge clk);
    if (q0.size() != 0) begin
      check("dut sweep_timeout", q0.size(), 0);
      q0.delete();
    end
  endtask

  task automatic sweep0(input exp_t e);
    q0.push_back(e);
    pulse_start();
    drain0(400);
  endtask

  initial begin
    #1 check("reset_outputs", int'({a_out, b_out, ci_out, busy, done, pass,
                                    err_count, fail_valid, fail_vec}), 0);
    check("reset_outputs5", int'({a5, b5, ci5, busy5, done5, pass5,
                                  err_count5, fail_valid5, fail_vec5}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    mode = 0; sweep0(mk(0, 1'b0, 5'd0, 1'b1));
    mode = 1; sweep0(mk(16, 1'b1, 5'd7, 1'b0));
    mode = 2; sweep0(mk(16, 1'b1, 5'd1, 1'b0));

    // Extra start at cycle 40 of the sweep must be ignored.
    mode = 0;
    q0.push_back(mk(0, 1'b0, 5'd0, 1'b1));
    pulse_start();
    repeat (38) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    drain0(400);
    sweep0(mk(0, 1'b0, 5'd0, 1'b1));

    // Asynchronous reset mid-sweep with errors already logged.
    mode = 1;
    pulse_start();
    repeat (58) @(negedge clk);
    check("errors_logged_before_reset", int'(fail_valid), 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_clears", int'({a_out, b_out, ci_out, busy, done, pass,
                                          err_count, fail_valid, fail_vec}), 0);
    @(negedge clk); rst_n = 1'b1;
    sweep0(mk(16, 1'b1, 5'd7, 1'b0));

    // Slow adder with too short a settle interval.
    mode = 3; sweep0(mk(-1, 1'b1, 5'd0, 1'b0));

    // Same slow adder against a 5-cycle settle interval.
    q5.push_back(mk(0, 1'b0, 5'd0, 1'b1));
    @(negedge clk); start5 = 1'b1;
    @(negedge clk); start5 = 1'b0;
    check("busy5_after_start", int'(busy5), 1);
    for (int i = 0; i < 600 && q5.size() != 0; i++) @(negedge clk);
    if (q5.size() != 0) begin
      check("dut5 sweep_timeout", q5.size(), 0);
      q5.delete();
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/adder_2bit_checker.md
Name: adder_2bit_checker

Overview:
- On-board self-test engine for the 2-bit ripple adder on the Spartan-3E kit.
- It is the response end of the adder's stimulus interface. It drives every {a,b,ci} combination into the adder under test, waits a settle interval, then reads s/co back and compares them against an internal golden sum.
- It reports busy/done/pass, a mismatch count and the first failing vector, so LEDs or the LCD can show the result without a simulator.

Parameters:
- W, 2, operand width of the adder under test; vector count N = 2^(2W+1).
- SETTLE_CYCLES, 2, clock cycles between driving a vector and sampling the response (min 1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to run a full sweep; honoured only in IDLE or DONE.
- a_out  output  W  operand a to adder under test.
- b_out  output  W  operand b to adder under test.
- ci_out  output  1  carry-in to adder under test.
- s_in  input  W  sum from adder under test.
- co_in  input  1  carry-out from adder under test.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; held until next start or reset.
- pass  output  1  valid when done: 1 if err_count==0.
- err_count  output  2W+2  number of mismatching vectors (max N, no saturation needed).
- fail_valid  output  1  at least one mismatch recorded this sweep.
- fail_vec  output  2W+1  first failing vector index, encoded as {a,b,ci}.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: all outputs 0, state IDLE, vector index v=0, settle counter 0. Reset asserted mid-sweep aborts immediately; no partial result is retained.
- Vector encoding: v is 2W+1 bits. a_out=v[2W:W+1], b_out=v[W:1], ci_out=v[0]. Vectors are applied in ascending order 0..N-1.
- Golden value: expected = a+b+ci computed at W+1 bits, compared against {co_in,s_in}.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE/DONE: on start=1 → clear err_count, fail_valid, fail_vec, done and pass; set v=0; enter DRIVE. busy rises on the same edge.
- DRIVE (1 cycle): a_out/b_out/ci_out take the encoding of v; load the settle counter; go to SETTLE.
- SETTLE (SETTLE_CYCLES cycles): outputs stable; go to CHECK when the counter expires.
- CHECK (1 cycle): sample {co_in,s_in} and compare.
  - On mismatch: err_count+1. If fail_valid==0, set fail_vec=v and fail_valid=1.
  - If v==N-1: go to DONE, busy=0, done=1, pass=(final err_count==0).
  - Otherwise: v+1, go to DRIVE.
- Latency: each vector costs SETTLE_CYCLES+2 cycles. done rises exactly N*(SETTLE_CYCLES+2) cycles after the edge that samples start. Default: 128 cycles.
- start while busy is ignored; the sweep is neither restarted nor extended.
- Operand outputs hold the last vector in DONE and return to 0 only on reset.
- A mismatch on the final vector is counted before done/pass are evaluated.
- Simultaneous start and entry into DONE: the start is ignored, because it arrived while busy.
- No combinational path from s_in/co_in to any output; all outputs are registered.

Test Plan:
- Ideal adder model, default params, start pulse → busy for 128 cycles; done=1, pass=1, err_count=0, fail_valid=0; a_out/b_out/ci_out step through 0..31 in order.
- co_in stuck at 0 → err_count=16, fail_valid=1, fail_vec=5'b00111 (a=0,b=3,ci=1), pass=0.
- s_in[0] stuck at 0 → err_count=16, fail_vec=5'b00001, pass=0.
- Start re-pulsed at cycle 40 of a sweep → ignored; done still at cycle 128. A second start after done clears all results and repeats the identical sweep.
- rst_n low at cycle 60 mid-sweep, with a faulty model that has already logged errors → all outputs 0 immediately (async); after release, start gives a fresh full sweep with correct counts.
- SETTLE_CYCLES=5, adder model with 4-cycle output delay → pass=1; done at 32*7=224 cycles. The same model with SETTLE_CYCLES=2 → pass=0, err_count>0.
